cpu_decode_stage: RTL and testbench
===================================

// Module: cpu_decode_stage
// PURPOSE
//  Registered instruction-decode pipeline stage for the simple CPU. Takes 32-bit instructions from fetch over a valid/ready
//  handshake, splits R-type/I-type fields, extends the 16-bit immediate to XLEN, and presents one decoded op to execute.
//  Optional register scoreboard stalls on RAW/WAW hazards until writeback clears the pending destination.
// PARAMETERS
//  XLEN       32  width of extended immediate output
//  IMM_SIGNED 1   1: sign-extend instr[15:0]; 0: zero-extend
//  NUM_REGS   32  architectural registers tracked by scoreboard (<=32; reg index = 5 bits)
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst           in   1     synchronous active-high reset
//  flush         in   1     discard held op (branch redirect)
//  in_valid      in   1     fetch presents in_instr
//  in_ready      out  1     stage accepts in_instr this cycle
//  in_instr      in   32    raw instruction
//  out_valid     out  1     decoded op held in stage
//  out_ready     in   1     execute consumes op this cycle
//  out_src_reg1  out  5     rs = instr[25:21]
//  out_src_reg2  out  5     R-type: rt = instr[20:16]; I-type: 0
//  out_src2_used out  1     1 for R-type only
//  out_dst_reg   out  5     R-type: rd = instr[15:11]; I-type: rt
//  out_imm       out  XLEN  extended immediate; 0 for R-type
//  out_imm_sel   out  1     1 = I-type (ALU uses out_imm)
//  wb_valid      in   1     writeback retires a destination this cycle
//  wb_reg        in   5     register being retired
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* fields=0, scoreboard busy bits all 0. in_ready may go high in the cycle after rst falls.
//  - Opcode = instr[31:26]; 6'b000000 = R-type, anything else = I-type. No field is ever driven to z.
//  - Single output register, latency 1: op captured at edge where in_valid&in_ready; out_valid high from next cycle.
//  - in_ready = (!out_valid | out_ready) & !hazard & !flush. Back-to-back throughput 1/cycle when no hazards.
//  - out_* fields hold stable while out_valid & !out_ready.
//  - Hazard: busy[src1] | (R-type & busy[src2]) | busy[dst]; reg 0 never busy, never a hazard.
//  - Scoreboard set: busy[dst] <= 1 on capture, if dst != 0. Clear: busy[wb_reg] <= 0 on wb_valid.
//  - Same-cycle wb_valid clears that reg for the hazard check (combinational bypass); same-cycle set and clear
//    of the same reg -> set wins.
//  - flush: out_valid <= 0 next edge; no capture that cycle; busy[out_dst_reg] of the flushed op cleared
//    (if out_valid). Other busy bits untouched (older ops still retire). flush with rst: rst wins.
//  - wb_valid for a non-busy reg: no effect. wb_reg >= NUM_REGS: ignored.
// CONFIGURATION
//  CPU_DECODE_SCOREBOARD_EN defined: scoreboard and hazard stall as above.
//  Undefined: no busy state, hazard tied 0, wb_valid/wb_reg ignored; in_ready = (!out_valid | out_ready) & !flush.
// STRUCTURE
//  cpu_pkg: opcode localparam OP_RTYPE=6'b000000, field bit-position constants, decoded-op struct typedef.
//  Sub-module cpu_scoreboard (NUM_REGS busy bits; set/clear/flush-clear ports; 3 combinational lookups).
// TESTING
//  1 Reset 3 cycles then in 32'h0022_1820 (add rd=3,rs=1,rt=2), out_ready=1 -> next cycle out_valid=1, src1=1, src2=2,
//    dst=3, src2_used=1, imm_sel=0, imm=0.
//  2 I-type 32'h2041_FFFF, IMM_SIGNED=1 -> imm=32'hFFFF_FFFF, dst=1, src2=0, imm_sel=1; IMM_SIGNED=0 -> 32'h0000_FFFF.
//  3 out_ready=0 two cycles with in_valid held -> in_ready=0, out_* stable; out_ready=1 -> next op captured same edge.
//  4 SCOREBOARD_EN: op writing r3, then op reading r3 -> in_ready=0 until wb_valid,wb_reg=3; captured that same cycle.
//  5 Op writing r0 then op reading r0 -> no stall, busy vector stays 0.
//  6 Hold op dst=5, assert flush -> out_valid=0 next cycle, busy[5]=0; op reading r5 accepted immediately after.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the simple CPU: opcode constant, instruction
// field positions and the decoded-op record held by the decode stage.
package cpu_pkg;

  localparam int INSTR_W   = 32;
  localparam int REG_IDX_W = 5;
  localparam int IMM_W     = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  // Instruction field bit positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Register-level view of one decoded op; the extended immediate is kept
  // separately because its width follows the XLEN parameter.
  typedef struct packed {
    reg_idx_t src1;
    reg_idx_t src2;
    logic     src2_used;
    reg_idx_t dst;
    logic     imm_sel;
  } decoded_op_t;

  // Split an instruction into its register fields. I-type ops read only rs
  // and write rt, so src2 is forced to 0 for them.
  function automatic decoded_op_t decode_fields(input logic [INSTR_W-1:0] instr);
    decoded_op_t op;
    logic        is_rtype;
    is_rtype     = (instr[OP_MSB:OP_LSB] == OP_RTYPE);
    op.src1      = instr[RS_MSB:RS_LSB];
    op.src2      = is_rtype ? instr[RT_MSB:RT_LSB] : '0;
    op.src2_used = is_rtype;
    op.dst       = is_rtype ? instr[RD_MSB:RD_LSB] : instr[RT_MSB:RT_LSB];
    op.imm_sel   = !is_rtype;
    return op;
  endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Register busy-bit scoreboard for the decode stage. One busy bit per
// architectural register (register 0 is never busy). Writeback clears are
// bypassed into the three lookups so a retiring register does not stall the
// op that depends on it in the same cycle; a same-cycle set beats a clear.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set_en,
  input  reg_idx_t       set_reg,
  input  logic           clr_en,
  input  reg_idx_t       clr_reg,
  input  logic           flush_clr_en,
  input  reg_idx_t       flush_clr_reg,
  input  reg_idx_t [2:0] lookup_reg,
  output logic     [2:0] lookup_busy
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [31:0]         busy_pad;

  genvar gi;

  // Next busy vector: clears first, then set so set wins on a collision
  always_comb begin
    busy_next = busy_reg;
    for (int i = 1; i < NUM_REGS; i++) begin
      if ((clr_en && clr_reg == 5'(i)) || (flush_clr_en && flush_clr_reg == 5'(i))) begin
        busy_next[i] = 1'b0;
      end
      if (set_en && set_reg == 5'(i)) begin
        busy_next[i] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Busy-bit state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Widen to the full 5-bit index space; untracked registers read as free
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pad
      if (gi < NUM_REGS) begin : g_live
        assign busy_pad[gi] = busy_reg[gi];
      end else begin : g_free
        assign busy_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // Lookups with same-cycle writeback bypass
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lookup
      assign lookup_busy[gi] = busy_pad[lookup_reg[gi]]
                               & ~(clr_en & (clr_reg == lookup_reg[gi]));
    end
  endgenerate

endmodule

// File: rtl/cpu_decode_stage.sv
// Registered instruction-decode stage: valid/ready in from fetch, one held
// decoded op out to execute, latency 1, throughput 1/cycle without hazards.
// Optional feature macro: CPU_DECODE_SCOREBOARD_EN enables the register
// scoreboard that stalls RAW/WAW hazards until writeback retires the register.
module cpu_decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit IMM_SIGNED = 1'b1,
  parameter int NUM_REGS   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_src_reg1,
  output logic [4:0]      out_src_reg2,
  output logic            out_src2_used,
  output logic [4:0]      out_dst_reg,
  output logic [XLEN-1:0] out_imm,
  output logic            out_imm_sel,
  input  logic            wb_valid,
  input  logic [4:0]      wb_reg
);

  decoded_op_t     dec_op;
  logic [XLEN-1:0] ext_imm;
  logic [XLEN-1:0] dec_imm;
  logic            hazard;
  logic            capture;

  decoded_op_t     op_reg;
  logic [XLEN-1:0] imm_reg;
  logic            valid_reg;

  // Field split of the incoming instruction
  always_comb begin
    dec_op = decode_fields(in_instr);
  end

  generate
    if (IMM_SIGNED) begin : g_sext
      assign ext_imm = {{(XLEN-IMM_W){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};
    end else begin : g_zext
      assign ext_imm = {{(XLEN-IMM_W){1'b0}}, in_instr[IMM_MSB:IMM_LSB]};
    end
  endgenerate

  // R-type ops carry no immediate
  assign dec_imm = dec_op.imm_sel ? ext_imm : '0;

`ifdef CPU_DECODE_SCOREBOARD_EN
  logic [2:0] lookup_busy;

  cpu_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .set_en        (capture && (dec_op.dst != '0)),
    .set_reg       (dec_op.dst),
    .clr_en        (wb_valid),
    .clr_reg       (wb_reg),
    .flush_clr_en  (flush && valid_reg),
    .flush_clr_reg (op_reg.dst),
    .lookup_reg    ({dec_op.dst, dec_op.src2, dec_op.src1}),
    .lookup_busy   (lookup_busy)
  );

  // src2 only matters for R-type; destination check covers WAW
  assign hazard = lookup_busy[0] | (dec_op.src2_used & lookup_busy[1]) | lookup_busy[2];
`else
  logic unused_wb;

  assign hazard    = 1'b0;
  assign unused_wb = wb_valid ^ (^wb_reg);
`endif

  // Accept when the output slot frees this cycle, no hazard and no redirect;
  // held low during reset so nothing is offered before the stage is clean
  assign in_ready = !rst && (!valid_reg || out_ready) && !hazard && !flush;
  assign capture  = in_valid && in_ready;

  // Output register: flush drops the op, capture replaces it, consume empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= '0;
      imm_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      op_reg    <= dec_op;
      imm_reg   <= dec_imm;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid     = valid_reg;
  assign out_src_reg1  = op_reg.src1;
  assign out_src_reg2  = op_reg.src2;
  assign out_src2_used = op_reg.src2_used;
  assign out_dst_reg   = op_reg.dst;
  assign out_imm       = imm_reg;
  assign out_imm_sel   = op_reg.imm_sel;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Testbench for cpu_decode_stage: directed scenarios plus a randomized run
// against a behavioural model (held op + set of registers with writes pending).
// A second instance with IMM_SIGNED=0 checks zero extension.
module tb_cpu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, wb_valid;
  logic [31:0] in_instr;
  logic [4:0]  wb_reg;
  logic        in_ready, out_valid, out_src2_used, out_imm_sel;
  logic [4:0]  out_src_reg1, out_src_reg2, out_dst_reg;
  logic [31:0] out_imm;
  logic        zx_in_ready, zx_out_valid, zx_src2_used, zx_imm_sel;
  logic [4:0]  zx_src1, zx_src2, zx_dst;
  logic [31:0] zx_imm;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu_decode_stage #(.XLEN(32), .IMM_SIGNED(1'b1), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_src_reg1(out_src_reg1), .out_src_reg2(out_src_reg2), .out_src2_used(out_src2_used),
    .out_dst_reg(out_dst_reg), .out_imm(out_imm), .out_imm_sel(out_imm_sel),
    .wb_valid(wb_valid), .wb_reg(wb_reg)
  );

  cpu_decode_stage #(.XLEN(32), .IMM_SIGNED(1'b0), .NUM_REGS(32)) dut_zx (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(zx_in_ready),
    .in_instr(in_instr), .out_valid(zx_out_valid), .out_ready(out_ready),
    .out_src_reg1(zx_src1), .out_src_reg2(zx_src2), .out_src2_used(zx_src2_used),
    .out_dst_reg(zx_dst), .out_imm(zx_imm), .out_imm_sel(zx_imm_sel),
    .wb_valid(wb_valid), .wb_reg(wb_reg)
  );

  // ---------------- reference decode (from the instruction format rules) ----
  function automatic bit is_r(input logic [31:0] i);
    return i[31:26] == 6'd0;
  endfunction
  function automatic logic [4:0] e_src2(input logic [31:0] i);
    return is_r(i) ? i[20:16] : 5'd0;
  endfunction
  function automatic logic [4:0] e_dst(input logic [31:0] i);
    return is_r(i) ? i[15:11] : i[20:16];
  endfunction
  function automatic logic [31:0] e_imm(input logic [31:0] i, input bit sgn);
    int v;
    if (is_r(i)) return 32'd0;
    v = i[15:0];
    if (sgn && i[15]) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    if ($urandom_range(0, 1) == 0) i[31:26] = 6'd0;
    else i[31:26] = 6'($urandom_range(1, 63));
    i[25:21] = 5'($urandom_range(0, 7));
    i[20:16] = 5'($urandom_range(0, 7));
    if (i[31:26] == 6'd0) i[15:11] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  task automatic idle_inputs;
    in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    flush = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0;
  endtask

  // Drain the output and retire every register so each test starts clean
  task automatic cleanup;
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      @(negedge clk); wb_valid = 1'b1; wb_reg = 5'(r);
    end
    @(negedge clk); wb_valid = 1'b0; wb_reg = 5'd0;
    @(negedge clk);
  endtask

  // ---------------- directed tests ------------------------------------------
  task automatic test_reset;
    rst = 1'b1; idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if ({out_src_reg1, out_src_reg2, out_dst_reg, out_src2_used, out_imm_sel} !== 17'd0)
      $display("FAIL reset fields got=%h exp=0", {out_src_reg1, out_src_reg2, out_dst_reg, out_src2_used, out_imm_sel}); else passed++;
    checks++; if (out_imm !== 32'd0) $display("FAIL reset out_imm got=%h exp=0", out_imm); else passed++;
    @(negedge clk); rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_rtype;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h0022_1820; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rtype in_ready got=%0b exp=1", in_ready); else passed++;
    @(negedge clk); in_valid = 1'b0;
    #1;
    $display("rtype: instr 00221820 -> src1=%0d src2=%0d dst=%0d", out_src_reg1, out_src_reg2, out_dst_reg);
    checks++; if (out_valid !== 1'b1) $display("FAIL rtype out_valid got=%0b exp=1", out_valid); else passed++;
    checks++; if ({out_src_reg1, out_src_reg2, out_dst_reg} !== {5'd1, 5'd2, 5'd3})
      $display("FAIL rtype regs got=%0d/%0d/%0d exp=1/2/3", out_src_reg1, out_src_reg2, out_dst_reg); else passed++;
    checks++; if ({out_src2_used, out_imm_sel} !== 2'b10)
      $display("FAIL rtype used/sel got=%0b%0b exp=10", out_src2_used, out_imm_sel); else passed++;
    checks++; if (out_imm !== 32'd0) $display("FAIL rtype out_imm got=%h exp=0", out_imm); else passed++;
    cleanup();
  endtask

  task automatic test_itype;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h2041_FFFF; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #1;
    $display("itype: instr 2041FFFF -> imm=%h zx_imm=%h", out_imm, zx_imm);
    checks++; if (out_imm !== 32'hFFFF_FFFF) $display("FAIL itype sext_imm got=%h exp=ffffffff", out_imm); else passed++;
    checks++; if (zx_imm !== 32'h0000_FFFF) $display("FAIL itype zext_imm got=%h exp=0000ffff", zx_imm); else passed++;
    checks++; if ({out_src_reg1, out_src_reg2, out_dst_reg} !== {5'd2, 5'd0, 5'd1})
      $display("FAIL itype regs got=%0d/%0d/%0d exp=2/0/1", out_src_reg1, out_src_reg2, out_dst_reg); else passed++;
    checks++; if ({out_valid, out_src2_used, out_imm_sel, zx_out_valid} !== 4'b1011)
      $display("FAIL itype flags got=%b exp=1011", {out_valid, out_src2_used, out_imm_sel, zx_out_valid}); else passed++;
    cleanup();
  endtask

  task automatic test_backpressure;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h2004_1234; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp first_ready got=%0b exp=1", in_ready); else passed++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); in_instr = 32'h2005_0055; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp stall_ready got=%0b exp=0", in_ready); else passed++;
      checks++; if ({out_valid, out_dst_reg, out_imm} !== {1'b1, 5'd4, 32'h0000_1234})
        $display("FAIL bp hold got=%0b/%0d/%h exp=1/4/00001234", out_valid, out_dst_reg, out_imm); else passed++;
    end
    @(negedge clk); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp release_ready got=%0b exp=1", in_ready); else passed++;
    @(negedge clk); in_valid = 1'b0;
    #1;
    $display("backpressure: next op dst=%0d imm=%h", out_dst_reg, out_imm);
    checks++; if ({out_valid, out_dst_reg, out_imm} !== {1'b1, 5'd5, 32'h0000_0055})
      $display("FAIL bp next got=%0b/%0d/%h exp=1/5/00000055", out_valid, out_dst_reg, out_imm); else passed++;
    cleanup();
  endtask

  task automatic test_hazard;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h2003_0007; out_ready = 1'b1;
    @(negedge clk); in_instr = 32'h0060_3000;
    #1;
`ifdef CPU_DECODE_SCOREBOARD_EN
    checks++; if (in_ready !== 1'b0) $display("FAIL hazard stall1 got=%0b exp=0", in_ready); else passed++;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL hazard stall2 got=%0b exp=0", in_ready); else passed++;
    @(negedge clk); wb_valid = 1'b1; wb_reg = 5'd3;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL hazard wb_bypass got=%0b exp=1", in_ready); else passed++;
`else
    checks++; if (in_ready !== 1'b1) $display("FAIL hazard no_sb_ready got=%0b exp=1", in_ready); else passed++;
`endif
    @(negedge clk); in_valid = 1'b0; wb_valid = 1'b0;
    #1;
    $display("hazard: reader captured src1=%0d dst=%0d", out_src_reg1, out_dst_reg);
    checks++; if ({out_valid, out_src_reg1, out_dst_reg} !== {1'b1, 5'd3, 5'd6})
      $display("FAIL hazard captured got=%0b/%0d/%0d exp=1/3/6", out_valid, out_src_reg1, out_dst_reg); else passed++;
    cleanup();
  endtask

  task automatic test_r0;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h2000_0009; out_ready = 1'b1;
    @(negedge clk); in_instr = 32'h0000_3800;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL r0 no_stall got=%0b exp=1", in_ready); else passed++;
    @(negedge clk); in_instr = 32'h2000_0001;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL r0 waw_r0 got=%0b exp=1", in_ready); else passed++;
    checks++; if ({out_valid, out_dst_reg} !== {1'b1, 5'd7})
      $display("FAIL r0 reader got=%0b/%0d exp=1/7", out_valid, out_dst_reg); else passed++;
    @(negedge clk); in_valid = 1'b0;
    $display("r0: writes to r0 never stall");
    cleanup();
  endtask

  task automatic test_flush;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h2005_0001; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush accept got=%0b exp=1", in_ready); else passed++;
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL flush ready_low got=%0b exp=0", in_ready); else passed++;
    checks++; if ({out_valid, out_dst_reg} !== {1'b1, 5'd5})
      $display("FAIL flush held got=%0b/%0d exp=1/5", out_valid, out_dst_reg); else passed++;
    @(negedge clk); flush = 1'b0; in_valid = 1'b1; in_instr = 32'h00A0_4000; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush dropped got=%0b exp=0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush r5_free got=%0b exp=1", in_ready); else passed++;
    @(negedge clk); in_valid = 1'b0;
    #1;
    $display("flush: reader of r5 captured src1=%0d dst=%0d", out_src_reg1, out_dst_reg);
    checks++; if ({out_valid, out_src_reg1, out_dst_reg} !== {1'b1, 5'd5, 5'd8})
      $display("FAIL flush reader got=%0b/%0d/%0d exp=1/5/8", out_valid, out_src_reg1, out_dst_reg); else passed++;
    cleanup();
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ins = 32'h200A_0000 + (32'(k) << 16) + 32'(k * 3);
      in_valid = (k < 4); in_instr = ins; out_ready = 1'b1;
      #1;
      if (k < 4) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b ready[%0d] got=%0b exp=1", k, in_ready); else passed++;
      end
      if (k > 0) begin
        $display("b2b: op %0d dst=%0d imm=%h", k - 1, out_dst_reg, out_imm);
        checks++; if ({out_valid, out_dst_reg, out_imm} !== {1'b1, 5'(9 + k), 32'((k - 1) * 3)})
          $display("FAIL b2b op[%0d] got=%0b/%0d/%h exp=1/%0d/%h", k - 1, out_valid, out_dst_reg, out_imm, 9 + k, (k - 1) * 3);
        else passed++;
      end
    end
    cleanup();
  endtask

  // ---------------- randomized run against the model -------------------------
  task automatic test_random;
    logic [31:0] pend;
    logic [31:0] hold_i;
    bit          hold_v, exp_rdy, haz;
    logic [4:0]  used [3];
    int          nused;
    pend = 32'd0; hold_v = 1'b0; hold_i = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_reg    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      haz = 1'b0;
`ifdef CPU_DECODE_SCOREBOARD_EN
      used[0] = in_instr[25:21];
      used[1] = e_dst(in_instr);
      used[2] = e_src2(in_instr);
      nused = is_r(in_instr) ? 3 : 2;
      for (int u = 0; u < nused; u++)
        if (used[u] != 5'd0 && pend[used[u]] && !(wb_valid && wb_reg == used[u])) haz = 1'b1;
`endif
      exp_rdy = (!hold_v || out_ready) && !flush && !haz;
      checks++; if (in_ready !== exp_rdy) $display("FAIL rand in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_rdy); else passed++;
      checks++; if (out_valid !== hold_v) $display("FAIL rand out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, hold_v); else passed++;
      if (hold_v) begin
        checks++;
        if ({out_src_reg1, out_src_reg2, out_dst_reg, out_src2_used, out_imm_sel}
            !== {hold_i[25:21], e_src2(hold_i), e_dst(hold_i), is_r(hold_i), !is_r(hold_i)})
          $display("FAIL rand fields cyc=%0d instr=%h got=%0d/%0d/%0d/%0b/%0b", cyc, hold_i,
                   out_src_reg1, out_src_reg2, out_dst_reg, out_src2_used, out_imm_sel);
        else passed++;
        checks++;
        if (out_imm !== e_imm(hold_i, 1'b1) || zx_imm !== e_imm(hold_i, 1'b0))
          $display("FAIL rand imm cyc=%0d instr=%h got=%h/%h exp=%h/%h", cyc, hold_i,
                   out_imm, zx_imm, e_imm(hold_i, 1'b1), e_imm(hold_i, 1'b0));
        else passed++;
      end
      // model update for the coming edge
      if (flush) begin
        if (hold_v) pend[e_dst(hold_i)] = 1'b0;
        hold_v = 1'b0;
      end
      if (wb_valid) pend[wb_reg] = 1'b0;
      if (in_valid && exp_rdy) begin
        $display("rand: cyc %0d accept %h", cyc, in_instr);
        hold_i = in_instr; hold_v = 1'b1;
        if (e_dst(in_instr) != 5'd0) pend[e_dst(in_instr)] = 1'b1;
      end else if (!flush && out_ready) begin
        hold_v = 1'b0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_backpressure();
    test_hazard();
    test_r0();
    test_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
